// File: rtl/mac8_wb_buffer.sv
// mac8_wb_buffer: in-order result FIFO between the mac8 unit and the shared writeback port.
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   flush_i             discards all buffered results
//   mac8_*_i / mac8_ready_o  result capture from the functional unit, ready = not full
//   wb_*_o / wb_ack_i   head entry presented to writeback, consumed on ack
//   level_o             occupancy; overflow_o sticky flag for a result offered while full
//   Optional macro MAC8_WB_BYPASS_EN: 0-cycle bypass of the inputs to writeback when empty.
package mac8_wb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  cause;
        logic [31:0] tval;
    } exception_t;
endpackage

module mac8_wb_buffer
    import mac8_wb_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int DATA_W        = 32,
    parameter int TRANS_ID_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     mac8_valid_i,
    input  logic [DATA_W-1:0]        mac8_result_i,
    input  logic [TRANS_ID_BITS-1:0] mac8_trans_id_i,
    input  exception_t               mac8_exception_i,
    output logic                     mac8_ready_o,
    output logic                     wb_valid_o,
    output logic [DATA_W-1:0]        wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output exception_t               wb_exception_o,
    input  logic                     wb_ack_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0]        res_q [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q  [DEPTH];
    exception_t               exc_q [DEPTH];
    logic [CW-1:0]            count_q;
    logic [PW-1:0]            rd_q, wr_q;
    logic                     ovf_q, empty, push, pop;

    assign empty        = (count_q == '0);
    assign mac8_ready_o = (count_q != CW'(DEPTH));
    assign pop          = !empty && wb_ack_i && !flush_i;
    assign level_o      = count_q;
    assign overflow_o   = ovf_q;

`ifdef MAC8_WB_BYPASS_EN
    logic byp;
    assign byp  = empty && mac8_valid_i && !flush_i;
    // A bypassed result acked in the same cycle never enters the FIFO
    assign push = mac8_valid_i && mac8_ready_o && !flush_i && !(byp && wb_ack_i);
`else
    assign push = mac8_valid_i && mac8_ready_o && !flush_i;
`endif

    always_comb begin
        wb_valid_o     = !empty;
        wb_result_o    = empty ? '0 : res_q[rd_q];
        wb_trans_id_o  = empty ? '0 : id_q[rd_q];
        wb_exception_o = empty ? '0 : exc_q[rd_q];
`ifdef MAC8_WB_BYPASS_EN
        if (byp) begin
            wb_valid_o     = 1'b1;
            wb_result_o    = mac8_result_i;
            wb_trans_id_o  = mac8_trans_id_i;
            wb_exception_o = mac8_exception_i;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            res_q[wr_q] <= mac8_result_i;
            id_q[wr_q]  <= mac8_trans_id_i;
            exc_q[wr_q] <= mac8_exception_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (mac8_valid_i && !mac8_ready_o && !flush_i)
                ovf_q <= 1'b1;
            if (flush_i) begin
                count_q <= '0;
                rd_q    <= '0;
                wr_q    <= '0;
            end else begin
                if (push)
                    wr_q <= wr_q + PW'(1);
                if (pop)
                    rd_q <= rd_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_mac8_wb_buffer.sv
// tb_mac8_wb_buffer: directed self-checking bench for mac8_wb_buffer (DEPTH=2).
module tb_mac8_wb_buffer;
    import mac8_wb_pkg::*;

`ifdef MAC8_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        mac8_valid_i = 1'b0;
    logic [31:0] mac8_result_i = '0;
    logic [3:0]  mac8_trans_id_i = '0;
    exception_t  mac8_exception_i = '0;
    logic        mac8_ready_o;
    logic        wb_valid_o;
    logic [31:0] wb_result_o;
    logic [3:0]  wb_trans_id_o;
    exception_t  wb_exception_o;
    logic        wb_ack_i = 1'b0;
    logic [1:0]  level_o;
    logic        overflow_o;

    int errs = 0;
    int checks = 0;
    int max_level = 0;

    mac8_wb_buffer #(.DEPTH(2), .DATA_W(32), .TRANS_ID_BITS(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .mac8_valid_i(mac8_valid_i), .mac8_result_i(mac8_result_i),
        .mac8_trans_id_i(mac8_trans_id_i), .mac8_exception_i(mac8_exception_i),
        .mac8_ready_o(mac8_ready_o), .wb_valid_o(wb_valid_o),
        .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_exception_o(wb_exception_o), .wb_ack_i(wb_ack_i),
        .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [31:0] res);
        mac8_valid_i           = v;
        mac8_trans_id_i        = id;
        mac8_result_i          = res;
        mac8_exception_i       = '0;
        mac8_exception_i.cause = {2'b00, id};
    endtask

    initial begin
        // reset
        #2;
        chk("rst_valid", wb_valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_result", wb_result_o, 0);
        chk("rst_id", wb_trans_id_o, 0);
        #10 rst_ni = 1'b1;
        tick();
        chk("rst_ready", mac8_ready_o, 1);

        // single push with ack held
        wb_ack_i = 1'b1;
        drive(1, 4'd3, 32'h1234);
        #1;
        chk("t1_same_valid", wb_valid_o, BYP);
        chk("t1_same_result", wb_result_o, BYP ? 32'h1234 : 32'h0);
        tick();
        drive(0, 4'd0, 32'h0);
        chk("t1_next_valid", wb_valid_o, !BYP);
        chk("t1_next_result", wb_result_o, BYP ? 32'h0 : 32'h1234);
        chk("t1_next_id", wb_trans_id_o, BYP ? 0 : 3);
        chk("t1_next_level", level_o, BYP ? 0 : 1);
        tick();
        chk("t1_drain_level", level_o, 0);
        chk("t1_drain_valid", wb_valid_o, 0);

        // fill to full, then drain in order
        wb_ack_i = 1'b0;
        drive(1, 4'd1, 32'h101);
        tick();
        drive(1, 4'd2, 32'h202);
        tick();
        drive(0, 4'd0, 32'h0);
        chk("t2_full_level", level_o, 2);
        chk("t2_full_ready", mac8_ready_o, 0);
        chk("t2_head_id", wb_trans_id_o, 1);
        chk("t2_head_result", wb_result_o, 32'h101);
        chk("t2_head_exc", wb_exception_o.cause, 1);
        wb_ack_i = 1'b1;
        tick();
        chk("t2_pop1_ready", mac8_ready_o, 1);
        chk("t2_pop1_level", level_o, 1);
        chk("t2_second_id", wb_trans_id_o, 2);
        chk("t2_second_result", wb_result_o, 32'h202);
        tick();
        wb_ack_i = 1'b0;
        chk("t2_empty_level", level_o, 0);
        chk("t2_empty_valid", wb_valid_o, 0);

        // full with simultaneous pop and refused push
        drive(1, 4'd6, 32'h606);
        tick();
        drive(1, 4'd7, 32'h707);
        tick();
        drive(1, 4'd5, 32'h505);
        wb_ack_i = 1'b1;
        #1;
        chk("t3_ready_full", mac8_ready_o, 0);
        tick();
        drive(0, 4'd0, 32'h0);
        wb_ack_i = 1'b0;
        chk("t3_ovf", overflow_o, 1);
        chk("t3_level", level_o, 1);
        chk("t3_head_id", wb_trans_id_o, 7);
        chk("t3_ready_back", mac8_ready_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t3_flush_level", level_o, 0);
        chk("t3_ovf_sticky", overflow_o, 1);

        // flush with concurrent push and ack
        drive(1, 4'd1, 32'h111);
        tick();
        drive(1, 4'd2, 32'h222);
        tick();
        chk("t4_pre_level", level_o, 2);
        drive(1, 4'd4, 32'h444);
        wb_ack_i = 1'b1;
        flush_i  = 1'b1;
        tick();
        drive(0, 4'd0, 32'h0);
        wb_ack_i = 1'b0;
        flush_i  = 1'b0;
        chk("t4_level", level_o, 0);
        chk("t4_valid", wb_valid_o, 0);
        chk("t4_result", wb_result_o, 0);
        tick();
        chk("t4_still_empty", level_o, 0);

        // continuous stream with ack every cycle
        wb_ack_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1, 4'(k), 32'(k * 32'h11));
            #1;
            if (int'(level_o) > max_level) max_level = int'(level_o);
            chk($sformatf("t5_valid%0d", k), wb_valid_o, BYP || k > 0);
            chk($sformatf("t5_id%0d", k), wb_trans_id_o,
                BYP ? k : (k > 0 ? k - 1 : 0));
            chk($sformatf("t5_res%0d", k), wb_result_o,
                BYP ? k * 32'h11 : (k > 0 ? (k - 1) * 32'h11 : 0));
            tick();
        end
        drive(0, 4'd0, 32'h0);
        if (int'(level_o) > max_level) max_level = int'(level_o);
        chk("t5_max_level", max_level, BYP ? 0 : 1);
        chk("t5_tail_valid", wb_valid_o, !BYP);
        chk("t5_tail_id", wb_trans_id_o, BYP ? 0 : 9);
        tick();
        wb_ack_i = 1'b0;
        chk("t5_end_level", level_o, 0);

        // asynchronous reset with one entry held
        drive(1, 4'hA, 32'hAAAA);
        tick();
        drive(0, 4'd0, 32'h0);
        chk("t6_held_level", level_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", wb_valid_o, 0);
        chk("t6_rst_level", level_o, 0);
        chk("t6_rst_ovf", overflow_o, 0);
        #2 rst_ni = 1'b1;
        tick();
        drive(1, 4'hB, 32'hBBBB);
        tick();
        drive(0, 4'd0, 32'h0);
        chk("t6_post_valid", wb_valid_o, 1);
        chk("t6_post_id", wb_trans_id_o, 32'hB);
        chk("t6_post_result", wb_result_o, 32'hBBBB);
        chk("t6_post_level", level_o, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mac8_wb_buffer.md
Name: mac8_wb_buffer

Overview:
- Sits directly downstream of the mac8 functional unit.
- Captures each completed MAC8_INIT/MAC8_ACC result (result, trans_id, exception) into a small in-order FIFO.
- Presents entries to the shared writeback port, which can stall via an acknowledge, and back-pressures the functional unit through its ready.
- A pipeline flush discards all buffered results.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.
- DATA_W, 32, result width; matches the mac8 result.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  pipeline flush; discards all entries
- mac8_valid_i  input  1  functional-unit result valid
- mac8_result_i  input  DATA_W  functional-unit result
- mac8_trans_id_i  input  TRANS_ID_BITS  scoreboard transaction id
- mac8_exception_i  input  exception_t  exception record from the functional unit
- mac8_ready_o  output  1  buffer can accept a result this cycle
- wb_valid_o  output  1  writeback entry valid
- wb_result_o  output  DATA_W  head result
- wb_trans_id_o  output  TRANS_ID_BITS  head transaction id
- wb_exception_o  output  exception_t  head exception record
- wb_ack_i  input  1  writeback port consumed the head this cycle
- level_o  output  $clog2(DEPTH)+1  current occupancy
- overflow_o  output  1  sticky: valid arrived while not ready

Behaviour:
- Reset (async, rst_ni=0):
  - Read pointer, write pointer and count = 0.
  - wb_valid_o=0; wb_result_o, wb_trans_id_o, wb_exception_o = 0.
  - level_o=0, overflow_o=0, mac8_ready_o=1 once reset is released.
  - Storage array contents need not be reset.
- mac8_ready_o = (count != DEPTH). Combinational from the count register only; it does not depend on wb_ack_i.
- Push:
  - Occurs when mac8_valid_i && mac8_ready_o && !flush_i.
  - Writes {result, trans_id, exception} at the write pointer; the pointer wraps modulo DEPTH.
- Pop:
  - Occurs when wb_valid_o && wb_ack_i && !flush_i.
  - Advances the read pointer, wrapping modulo DEPTH.
  - wb_ack_i while wb_valid_o=0 is ignored.
- Count: +1 on push only, -1 on pop only, unchanged when both occur in the same cycle.
- Full with a pop in the same cycle: the push is still refused (ready=0); the pop proceeds, and ready rises the next cycle.
- Empty with a push in the same cycle: the entry becomes visible the next cycle (latency 1 without the optional feature).
- Head outputs:
  - wb_valid_o = (count != 0); the head fields are driven from the read-pointer entry.
  - When empty, all head fields are forced to 0.
- Ordering: strict FIFO; trans_id order at the output equals arrival order.
- Flush:
  - In the flush cycle, any push and pop are suppressed.
  - Next cycle: count=0, pointers=0, wb_valid_o=0.
  - overflow_o is not cleared by flush.
- Overflow: mac8_valid_i=1 while mac8_ready_o=0 and !flush_i sets overflow_o; it is cleared only by reset. The offending data is dropped.
- Reset mid-operation: all entries are lost, and the outputs take their reset values immediately.

Optional Feature:
- Macro: MAC8_WB_BYPASS_EN.
- Defined — bypass when count==0 and mac8_valid_i && !flush_i:
  - wb_valid_o=1 combinationally in the same cycle, with the head fields taken directly from the mac8_* inputs (0-cycle latency).
  - If wb_ack_i=1 in that cycle, the entry is consumed and not written; count stays 0.
  - If wb_ack_i=0, the entry is written as a normal push.
  - mac8_ready_o is unchanged.
- Undefined: no combinational path from the mac8_* inputs to the wb_* outputs; latency is always 1 cycle or more.

Test Plan:
- Reset, then one push of result 0x0000_1234 with trans_id 3 and wb_ack_i=1 held:
  - wb_valid_o=1 with 0x1234/id 3 on the next cycle (same cycle with bypass).
  - It pops, and level_o returns to 0.
- Push ids 1 and 2 with wb_ack_i=0 (DEPTH=2):
  - level_o=2, mac8_ready_o=0.
  - Assert wb_ack_i for 2 cycles → output order id 1 then id 2; mac8_ready_o=1 after the first pop.
- Full buffer; in the same cycle mac8_valid_i=1 (id 5) and wb_ack_i=1:
  - The pop occurs, id 5 is refused, overflow_o=1, level_o=1.
  - overflow_o remains 1 after a later flush.
- Two entries buffered; flush_i for 1 cycle together with mac8_valid_i and wb_ack_i:
  - Next cycle level_o=0 and wb_valid_o=0; neither a push nor a pop occurred.
- Continuous push with wb_ack_i=1 every cycle for 10 results (ids 0..9, result = id*0x11):
  - All 10 appear in order; pointers wrap; level_o never exceeds 1 (never exceeds 0 with bypass).
- Assert rst_ni=0 mid-stream with 1 entry held:
  - wb_valid_o=0 and level_o=0 immediately.
  - The first push after release appears normally.
